// File: rtl/alu_issue_queue.sv
// ALU issue queue: multi-port dispatch into free slots, tag-broadcast wakeup,
// oldest-first selection onto ISS_W ALUs with registered issue outputs.
module alu_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int DISP_W = 2,
    parameter int ISS_W  = 2,
    parameter int WB_W   = 2,
    parameter int PREG_W = 8,
    parameter int ROB_W  = 4,
    parameter int AGE_W  = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               flush,
    input  logic [DISP_W-1:0]                                  valid_in,
    output logic [DISP_W-1:0]                                  ready_in,
    input  logic [DISP_W-1:0][7+3*PREG_W+2+32+ROB_W-1:0]       instr_in,
    input  logic [WB_W-1:0]                                    wb_valid,
    input  logic [WB_W-1:0][PREG_W-1:0]                        wb_preg,
    input  logic [ISS_W-1:0]                                   fu_rdy,
    output logic [ISS_W-1:0]                                   valid_out,
    output logic [ISS_W-1:0][7+3*PREG_W+32+ROB_W-1:0]          data_out,
    output logic [$clog2(DEPTH):0]                             free_count
);

    localparam int IN_W  = 7 + 3*PREG_W + 2 + 32 + ROB_W;
    localparam int OUT_W = 7 + 3*PREG_W + 32 + ROB_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int P2_LO = ROB_W + 32;
    localparam int P1_LO = P2_LO + PREG_W;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] rdy1;
    logic [DEPTH-1:0] rdy2;
    logic [AGE_W-1:0] age [DEPTH];
    logic [OUT_W-1:0] pay [DEPTH];

    // Tag 0 is the hardwired zero register: it is never broadcast-matched.
    function automatic logic tag_hit(input logic [PREG_W-1:0]            tag,
                                     input logic [WB_W-1:0]              vld,
                                     input logic [WB_W-1:0][PREG_W-1:0]  preg);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < WB_W; j++)
            if (vld[j] && (preg[j] == tag) && (tag != '0))
                hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [OUT_W-1:0] in_pay(input logic [IN_W-1:0] w);
        return {w[IN_W-1 -: 7+3*PREG_W], w[ROB_W+32-1:0]};
    endfunction

    function automatic logic [PREG_W-1:0] in_pr1(input logic [IN_W-1:0] w);
        return w[ROB_W+34+PREG_W +: PREG_W];
    endfunction

    function automatic logic [PREG_W-1:0] in_pr2(input logic [IN_W-1:0] w);
        return w[ROB_W+34 +: PREG_W];
    endfunction

    always_comb begin
        for (int i = 0; i < DISP_W; i++)
            ready_in[i] = (free_count > CNT_W'(i)) && !flush;
    end

    // Dispatch allocation: accepted ports take the lowest free slots in port order.
    logic [DEPTH-1:0]             alloc_mask;
    logic [DISP_W-1:0]            alloc_vld;
    logic [DISP_W-1:0][IDX_W-1:0] alloc_idx;
    logic [DISP_W-1:0]            new_r1;
    logic [DISP_W-1:0]            new_r2;

    always_comb begin
        alloc_mask = '0;
        alloc_vld  = '0;
        alloc_idx  = '0;
        new_r1     = '0;
        new_r2     = '0;
        for (int i = 0; i < DISP_W; i++) begin
            new_r1[i] = instr_in[i][ROB_W+33] || (in_pr1(instr_in[i]) == '0) ||
                        tag_hit(in_pr1(instr_in[i]), wb_valid, wb_preg);
            new_r2[i] = instr_in[i][ROB_W+32] || (in_pr2(instr_in[i]) == '0) ||
                        tag_hit(in_pr2(instr_in[i]), wb_valid, wb_preg);
            if (valid_in[i] && ready_in[i]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (!occ[e] && !alloc_mask[e] && !alloc_vld[i]) begin
                        alloc_vld[i]  = 1'b1;
                        alloc_idx[i]  = IDX_W'(e);
                        alloc_mask[e] = 1'b1;
                    end
                end
            end
        end
    end

    logic [DEPTH-1:0] wake1;
    logic [DEPTH-1:0] wake2;

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wake1[e] = tag_hit(pay[e][P1_LO +: PREG_W], wb_valid, wb_preg);
            wake2[e] = tag_hit(pay[e][P2_LO +: PREG_W], wb_valid, wb_preg);
        end
    end

    // Stage p0: select from registered queue state, ALUs in ascending order.
    logic [DEPTH-1:0]            issue_mask;
    logic [ISS_W-1:0]            sel_vld_p0;
    logic [ISS_W-1:0][IDX_W-1:0] sel_idx_p0;
    logic                        sel_found;
    logic [IDX_W-1:0]            sel_best;
    logic [AGE_W-1:0]            sel_age;

    always_comb begin
        issue_mask = '0;
        sel_vld_p0 = '0;
        sel_idx_p0 = '0;
        sel_found  = 1'b0;
        sel_best   = '0;
        sel_age    = '0;
        for (int k = 0; k < ISS_W; k++) begin
            sel_found = 1'b0;
            sel_best  = '0;
            sel_age   = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (occ[e] && rdy1[e] && rdy2[e] && !issue_mask[e] &&
                    (!sel_found || (age[e] > sel_age))) begin
                    sel_found = 1'b1;
                    sel_best  = IDX_W'(e);
                    sel_age   = age[e];
                end
            end
            if (fu_rdy[k] && sel_found) begin
                sel_vld_p0[k]        = 1'b1;
                sel_idx_p0[k]        = sel_best;
                issue_mask[sel_best] = 1'b1;
            end
        end
    end

    logic [DEPTH-1:0] occ_next;
    logic [CNT_W-1:0] free_next;

    always_comb begin
        occ_next  = flush ? '0 : ((occ & ~issue_mask) | alloc_mask);
        free_next = CNT_W'(DEPTH);
        for (int e = 0; e < DEPTH; e++)
            free_next = free_next - CNT_W'(occ_next[e]);
    end

    // Stage p1: issue registers and queue state update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ        <= '0;
            rdy1       <= '0;
            rdy2       <= '0;
            for (int e = 0; e < DEPTH; e++)
                age[e] <= '0;
            valid_out  <= '0;
            data_out   <= '0;
            free_count <= CNT_W'(DEPTH);
        end else begin
            occ        <= occ_next;
            free_count <= free_next;
            if (flush) begin
                valid_out <= '0;
            end else begin
                for (int k = 0; k < ISS_W; k++) begin
                    valid_out[k] <= sel_vld_p0[k];
                    if (sel_vld_p0[k])
                        data_out[k] <= pay[sel_idx_p0[k]];
                end
                for (int e = 0; e < DEPTH; e++) begin
                    if (occ[e] && !issue_mask[e]) begin
                        if (wake1[e])
                            rdy1[e] <= 1'b1;
                        if (wake2[e])
                            rdy2[e] <= 1'b1;
                        if (age[e] != AGE_MAX)
                            age[e] <= age[e] + 1'b1;
                    end
                end
                for (int i = 0; i < DISP_W; i++) begin
                    if (alloc_vld[i]) begin
                        rdy1[alloc_idx[i]] <= new_r1[i];
                        rdy2[alloc_idx[i]] <= new_r2[i];
                        age[alloc_idx[i]]  <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_W; i++)
            if (alloc_vld[i])
                pay[alloc_idx[i]] <= in_pay(instr_in[i]);
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: slot-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_issue_queue;

    localparam int DEPTH = 8;
    localparam int IN_W  = 69;
    localparam int OUT_W = 67;

    logic                   clk      = 1'b0;
    logic                   reset    = 1'b0;
    logic                   flush    = 1'b0;
    logic [1:0]             valid_in = '0;
    logic [1:0]             ready_in;
    logic [1:0][IN_W-1:0]   instr_in = '0;
    logic [1:0]             wb_valid = '0;
    logic [1:0][7:0]        wb_preg  = '0;
    logic [1:0]             fu_rdy   = '0;
    logic [1:0]             valid_out;
    logic [1:0][OUT_W-1:0]  data_out;
    logic [3:0]             free_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_queue #(.DEPTH(8), .DISP_W(2), .ISS_W(2), .WB_W(2),
                      .PREG_W(8), .ROB_W(4), .AGE_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .ready_in(ready_in), .instr_in(instr_in),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .fu_rdy(fu_rdy),
        .valid_out(valid_out), .data_out(data_out), .free_count(free_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] mk(input logic [7:0] p1, input bit r1,
                                           input logic [7:0] p2, input bit r2,
                                           input logic [3:0] rob);
        return {7'h33, 8'h80 + {4'h0, rob}, p1, p2, r1, r2, 32'hA5A5_0000 + {28'h0, rob}, rob};
    endfunction

    // Reference model: one record per queue slot.
    typedef struct {
        bit               occ;
        bit               r1;
        bit               r2;
        int               age;
        logic [7:0]       p1;
        logic [7:0]       p2;
        logic [OUT_W-1:0] pay;
    } ent_t;

    ent_t             q [DEPTH];
    bit               issued [DEPTH];
    bit               was_free [DEPTH];
    logic [1:0]       exp_valid = '0;
    logic [OUT_W-1:0] exp_data [2] = '{default: '0};
    int               exp_free = DEPTH;
    int               m_best, m_nfree, m_slot;
    logic [IN_W-1:0]  m_ins;

    function automatic bit woken(input logic [7:0] tag);
        bit w;
        w = 0;
        if (tag != 8'd0)
            for (int j = 0; j < 2; j++)
                if (wb_valid[j] && wb_preg[j] == tag) w = 1;
        return w;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (q[e]) begin
                q[e].occ = 0; q[e].r1 = 0; q[e].r2 = 0; q[e].age = 0;
            end
            exp_valid   = '0;
            exp_data[0] = '0;
            exp_data[1] = '0;
            exp_free    = DEPTH;
        end else if (flush) begin
            foreach (q[e]) q[e].occ = 0;
            exp_valid = '0;
            exp_free  = DEPTH;
        end else begin
            m_nfree = 0;
            foreach (q[e]) begin
                issued[e]   = 0;
                was_free[e] = !q[e].occ;
                if (!q[e].occ) m_nfree++;
            end
            for (int k = 0; k < 2; k++) begin
                exp_valid[k] = 0;
                if (fu_rdy[k]) begin
                    m_best = -1;
                    foreach (q[e])
                        if (q[e].occ && q[e].r1 && q[e].r2 && !issued[e])
                            if (m_best < 0 || q[e].age > q[m_best].age) m_best = e;
                    if (m_best >= 0) begin
                        exp_valid[k]   = 1;
                        exp_data[k]    = q[m_best].pay;
                        issued[m_best] = 1;
                    end
                end
            end
            foreach (q[e]) begin
                if (q[e].occ && !issued[e]) begin
                    if (woken(q[e].p1)) q[e].r1 = 1;
                    if (woken(q[e].p2)) q[e].r2 = 1;
                    if (q[e].age < 15) q[e].age++;
                end
                if (issued[e]) q[e].occ = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (valid_in[i] && m_nfree > i) begin
                    m_ins  = instr_in[i];
                    m_slot = -1;
                    foreach (q[e]) if (m_slot < 0 && was_free[e]) m_slot = e;
                    if (m_slot >= 0) begin
                        was_free[m_slot]  = 0;
                        q[m_slot].occ = 1;
                        q[m_slot].age = 0;
                        q[m_slot].p1  = m_ins[53:46];
                        q[m_slot].p2  = m_ins[45:38];
                        q[m_slot].r1  = m_ins[37] || m_ins[53:46] == 8'd0 || woken(m_ins[53:46]);
                        q[m_slot].r2  = m_ins[36] || m_ins[45:38] == 8'd0 || woken(m_ins[45:38]);
                        q[m_slot].pay = {m_ins[68:38], m_ins[35:0]};
                    end
                end
            end
            exp_free = 0;
            foreach (q[e]) if (!q[e].occ) exp_free++;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("model valid_out", 128'(valid_out[k]), 128'(exp_valid[k]));
            check("model data_out", 128'(data_out[k]), 128'(exp_data[k]));
        end
        check("model free_count", 128'(free_count), 128'(exp_free));
        check("model ready_in", 128'(ready_in),
              128'({(exp_free > 1) && !flush, (exp_free > 0) && !flush}));
    end

    task automatic disp(input int port, input logic [IN_W-1:0] ins);
        valid_in[port] = 1'b1;
        instr_in[port] = ins;
    endtask

    task automatic wb(input int j, input logic [7:0] tag);
        wb_valid[j] = 1'b1;
        wb_preg[j]  = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        valid_in = '0;
        wb_valid = '0;
        flush    = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset free_count", free_count, 4'd8);
        check("reset valid_out", valid_out, 2'b00);
        check("reset ready_in", ready_in, 2'b11);
        check("reset data_out0", data_out[0], '0);
        check("reset data_out1", data_out[1], '0);
        reset = 1'b1;

        // Fill with operands waiting on pr1
        for (int c = 0; c < 4; c++) begin
            disp(0, mk(8'd40 + 8'(2*c), 0, 8'd60, 1, 4'(2*c)));
            disp(1, mk(8'd41 + 8'(2*c), 0, 8'd60, 1, 4'(2*c+1)));
            tick();
            check("fill free_count", free_count, 4'(6 - 2*c));
        end
        check("full ready_in", ready_in, 2'b00);

        fu_rdy = 2'b01;
        wb(0, 8'd40);
        tick();
        check("wakeup not same edge", valid_out, 2'b00);
        tick();
        check("wakeup next edge", valid_out, 2'b01);
        check("wakeup rob", data_out[0][3:0], 4'd0);
        check("one free count", free_count, 4'd1);
        check("one free ready_in", ready_in, 2'b01);

        disp(0, mk(8'd48, 0, 8'd60, 1, 4'd8));
        tick();
        check("refill free_count", free_count, 4'd0);
        check("refill valid_out", valid_out, 2'b00);

        fu_rdy = 2'b11;
        wb(1, 8'd41);
        tick();
        flush = 1'b1;
        disp(0, mk(8'd1, 1, 8'd2, 1, 4'd14));
        disp(1, mk(8'd1, 1, 8'd2, 1, 4'd15));
        tick();
        check("flush free_count", free_count, 4'd8);
        check("flush valid_out", valid_out, 2'b00);

        // Oldest-first beats lowest index
        disp(0, mk(8'd51, 0, 8'd60, 1, 4'd1));
        disp(1, mk(8'd52, 0, 8'd60, 1, 4'd2));
        tick();
        disp(0, mk(8'd53, 0, 8'd60, 1, 4'd3));
        disp(1, mk(8'd53, 0, 8'd60, 1, 4'd4));
        tick();
        wb(0, 8'd51);
        tick();
        tick();
        check("age early issue", valid_out, 2'b01);
        check("age early rob", data_out[0][3:0], 4'd1);
        disp(0, mk(8'd53, 0, 8'd60, 1, 4'd5));
        tick();
        check("reuse free_count", free_count, 4'd4);
        wb(1, 8'd53);
        tick();
        tick();
        check("oldest valid_out", valid_out, 2'b11);
        check("oldest alu0 rob", data_out[0][3:0], 4'd3);
        check("oldest alu1 rob", data_out[1][3:0], 4'd4);
        tick();
        check("young valid_out", valid_out, 2'b01);
        check("young rob", data_out[0][3:0], 4'd5);

        // Backpressure on ALU1
        fu_rdy = 2'b01;
        disp(0, mk(8'd71, 1, 8'd72, 1, 4'd6));
        disp(1, mk(8'd71, 1, 8'd72, 1, 4'd7));
        tick();
        tick();
        check("bp first valid", valid_out, 2'b01);
        check("bp first rob", data_out[0][3:0], 4'd6);
        tick();
        check("bp second valid", valid_out, 2'b01);
        check("bp second rob", data_out[0][3:0], 4'd7);
        tick();
        check("bp drained", valid_out, 2'b00);

        // Same-cycle bypass and minimum latency
        fu_rdy = 2'b11;
        disp(0, mk(8'd70, 1, 8'd20, 0, 4'd8));
        disp(1, mk(8'd73, 1, 8'd74, 1, 4'd9));
        wb(1, 8'd20);
        tick();
        tick();
        check("bypass valid", valid_out, 2'b11);
        check("bypass rob", data_out[0][3:0], 4'd8);
        check("latency rob", data_out[1][3:0], 4'd9);

        // Asynchronous reset in the middle of issue
        disp(0, mk(8'd75, 1, 8'd76, 1, 4'd10));
        disp(1, mk(8'd77, 1, 8'd78, 1, 4'd11));
        tick();
        disp(0, mk(8'd79, 0, 8'd80, 1, 4'd12));
        tick();
        check("pre-reset valid", valid_out, 2'b11);
        reset = 1'b0;
        #1;
        check("async reset valid", valid_out, 2'b00);
        check("async reset data0", data_out[0], '0);
        check("async reset data1", data_out[1], '0);
        check("async reset free", free_count, 4'd8);
        check("async reset ready", ready_in, 2'b11);
        disp(0, mk(8'd81, 1, 8'd82, 1, 4'd13));
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("held reset free", free_count, 4'd8);
        tick();
        check("first accept free", free_count, 4'd7);
        check("no stale issue", valid_out, 2'b00);
        tick();
        check("post-reset issue", valid_out, 2'b01);
        check("post-reset rob", data_out[0][3:0], 4'd13);
        check("post-reset free", free_count, 4'd8);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
